sev_seg_scan: RTL and testbench
===============================

// Module: sev_seg_scan
// PURPOSE
//  Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
//  Holds one 4-bit code per digit and selects one digit at a time (active-low anode).
//  Presents that digit's code on num_out, which feeds set_sev_seg (code -> segments).
//  New values are double-buffered and committed only at a frame boundary (no tearing).
//  Optional leading-zero blanking.
// PARAMETERS
//  N_DIGITS     4       number of digits scanned; >=2
//  REFRESH_DIV  100000  clk cycles each digit stays selected; >=2
//  CNT_W        $clog2(REFRESH_DIV)  refresh counter width (derived, localparam)
// PORTS
//  clk         in   1           system clock; single clock domain
//  rst         in   1           synchronous, active-high reset
//  load        in   1           1-cycle strobe: capture digits_in
//  digits_in   in   4*N_DIGITS  digit codes; [3:0] = digit 0 (rightmost)
//  blank_lz    in   1           1 = blank leading zeros
//  pending     out  1           1 = captured value not yet committed
//  an_out      out  N_DIGITS    anode enables, active-low, one-hot-zero
//  num_out     out  4           code for selected digit -> set_sev_seg.num
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - cnt=0, idx=0, disp=all 4'hF, pend_valid=0.
//   - an_out = all 1s, num_out = 4'hF (blank code).
//   - Reset mid-operation drops any pending value.
//  Refresh counter
//   - cnt counts 0..REFRESH_DIV-1 and wraps.
//   - tick = (cnt == REFRESH_DIV-1).
//   - On tick, idx increments 0..N_DIGITS-1 and wraps to 0.
//  Frame boundary
//   - boundary = tick && idx == N_DIGITS-1.
//  Load / commit, priority top-down
//   - boundary && load: disp <= digits_in; pend_valid <= 0.
//   - boundary && pend_valid: disp <= pend; pend_valid <= 0.
//   - load (not boundary): pend <= digits_in; pend_valid <= 1.
//     A later load overwrites an earlier uncommitted one.
//   - pending = pend_valid (registered).
//  Outputs
//   - Registered every cycle: an_out <= ~(1 << idx); num_out <= eff(idx).
//   - Outputs lag idx by exactly 1 cycle.
//   - First cycle after reset release: an_out = ~1.
//  Digit value eff(i)
//   - Default: disp[4i+3:4i].
//   - If blank_lz=1, i>0, and digits i..N_DIGITS-1 are all 4'h0: eff(i) = 4'hF.
//   - Digit 0 is never blanked.
//  Codes
//   - Codes pass through unmodified.
//   - 0-9 digit, 10 = "-", 11-15 blank in the decoder.
//   - Blanking only applies to code 0.
//  blank_lz is sampled live every cycle; it is not buffered.
// TESTING  (N_DIGITS=4, REFRESH_DIV=4)
//  1. Reset: rst=1 for 3 cycles -> an_out=1111, num_out=F, pending=0.
//     1 cycle after release: an_out=1110, num_out=F.
//  2. Scan order: free-run -> an_out holds each of 1110,1101,1011,0111 for 4 cycles,
//     then repeats 1110.
//  3. Mid-frame load 16'h1234 (idx=1) -> pending=1 until boundary, then 0.
//     Next frame num_out = 4,3,2,1 with an_out = 1110,1101,1011,0111.
//  4. LZ blanking, blank_lz=1:
//     - 16'h0070 -> num_out = 0,7,F,F.
//     - 16'h0000 -> num_out = 0,F,F,F.
//     - blank_lz=0 -> 0,0,0,0.
//     - 16'hA005 -> 5,0,0,A; zeros below a nonzero digit are not blanked.
//  5. Loads 16'h1111 then 16'h2222 before a boundary -> only 2222 is ever displayed.
//     Load asserted exactly on the boundary cycle -> committed directly, pending stays 0.
//  6. Load 16'h9999, then rst=1 before the boundary -> pending=0, display stays F.
//     9 never appears after reset.

Source files
------------

// File: rtl/sev_seg_scan.sv
// Scan driver for an N-digit common-anode 7-segment display.
// Double-buffered digit codes commit at frame boundaries; optional leading-zero blanking.
module sev_seg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic                  blank_lz,
    output logic                  pending,
    output logic [N_DIGITS-1:0]   an_out,
    output logic [3:0]            num_out
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int DW    = 4 * N_DIGITS;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic [DW-1:0]       pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [3:0]          num_q, num_d;

    logic                tick;
    logic                boundary;
    logic                zero_run;
    logic [N_DIGITS-1:0] blank;

    always_comb begin
        tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        boundary = tick && (idx_q == IDX_W'(N_DIGITS - 1));
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (boundary && load) begin
            disp_d       = digits_in;
            pend_valid_d = 1'b0;
        end else if (boundary && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = digits_in;
            pend_valid_d = 1'b1;
        end
    end

    // A digit blanks only if it and every digit to its left are zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
            blank[i] = blank_lz && (i != 0) && zero_run;
        end
    end

    always_comb begin
        an_d  = ~(N_DIGITS'(1) << idx_q);
        num_d = blank[idx_q] ? 4'hF : disp_q[{idx_q, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '1;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '1;
            num_q        <= 4'hF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            num_q        <= num_d;
        end
    end

    assign pending = pend_valid_q;
    assign an_out  = an_q;
    assign num_out = num_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan: a cycle-level reference model feeds a queue,
// a monitor compares DUT outputs against it every cycle.
module tb_sev_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FR = ND * RD;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   digits_in;
    logic          blank_lz;
    logic          pending;
    logic [3:0]    an_out;
    logic [3:0]    num_out;

    logic [8:0]    exp_q[$];
    int            t;
    int            total = 0;
    int            bad   = 0;

    sev_seg_scan #(.N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .pending   (pending),
        .an_out    (an_out),
        .num_out   (num_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] eff(input int i, input logic [15:0] d,
                                       input logic b);
        logic [15:0] hi;
        hi = d >> (4 * i);
        if (b && i > 0 && hi == 16'h0) return 4'hF;
        return hi[3:0];
    endfunction

    // Reference model: time since reset gives the digit being shown.
    initial begin
        logic [15:0] disp_m;
        logic [15:0] pend_m;
        logic        pv;
        logic [3:0]  a;
        logic [3:0]  n;
        int          i;
        t      = 0;
        disp_m = 16'hFFFF;
        pend_m = 16'h0;
        pv     = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                t      = 0;
                disp_m = 16'hFFFF;
                pv     = 1'b0;
                exp_q.push_back({4'hF, 4'hF, 1'b0});
            end else begin
                i    = (t / RD) % ND;
                a    = 4'hF;
                a[i] = 1'b0;
                n    = eff(i, disp_m, blank_lz);
                if ((t % FR) == FR - 1) begin
                    if (load) disp_m = digits_in;
                    else if (pv) disp_m = pend_m;
                    pv = 1'b0;
                end else if (load) begin
                    pend_m = digits_in;
                    pv     = 1'b1;
                end
                t++;
                exp_q.push_back({a, n, pv});
            end
        end
    end

    // Monitor
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({an_out, num_out, pending} !== e) begin
                    bad++;
                    $display("FAIL scan t=%0t: got an=%b num=%h pend=%b exp an=%b num=%h pend=%b",
                             $time, an_out, num_out, pending, e[8:5], e[4:1], e[0]);
                end
            end
        end
    end

    task automatic goto(input int ph);
        int n;
        n = 0;
        while ((t % FR) != ph && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL goto: phase %0d not reached, at %0d", ph, t % FR);
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        load      = 1'b1;
        digits_in = d;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0;
        blank_lz  = 1'b0;
        run(3);
        rst = 1'b0;
        run(2 * FR);

        goto(5);
        do_load(16'h1234);
        run(2 * FR);

        blank_lz = 1'b1;
        goto(2);
        do_load(16'h0070);
        run(2 * FR);
        goto(2);
        do_load(16'h0000);
        run(2 * FR);
        blank_lz = 1'b0;
        run(FR);
        blank_lz = 1'b1;
        goto(2);
        do_load(16'hA005);
        run(2 * FR);

        goto(2);
        do_load(16'h1111);
        goto(6);
        do_load(16'h2222);
        run(2 * FR);

        goto(15);
        do_load(16'h5678);
        run(FR);

        goto(3);
        do_load(16'h9999);
        goto(8);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2 * FR);

        for (int k = 0; k < 600; k++) begin
            logic [15:0] d;
            for (int j = 0; j < 4; j++) begin
                d[4*j +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            end
            load      = ($urandom % 6 == 0);
            digits_in = d;
            if ($urandom % 20 == 0) blank_lz = ~blank_lz;
            rst = ($urandom % 150 == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        run(4);
        #1;
        if (total < 500) begin
            bad++;
            $display("FAIL count: total=%0d below 500", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
